// File: rtl/line_refill_engine.sv
// line_refill_engine
//   Cache-side initiator of the line-request memory protocol. It accepts one
//   miss at a time from a blocking cache controller. A dirty victim is written
//   back first, then the missing line is fetched. The result goes back to the
//   cache as a one-cycle fill pulse. A response timeout keeps a lost read
//   response from hanging the cache.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   miss_*              miss handshake and the captured miss/victim information
//   fill_*              one-cycle fill pulse; fill_line/fill_addr hold afterwards
//   mem_req_*           readline/writeline request channel (valid/ready)
//   mem_resp_*          single-cycle read response pulse
//   timeout_sticky      set on any response timeout, cleared only by reset
//   spurious_sticky     set on a response outside RD_WAIT, cleared only by reset
//
// States
//   IDLE    | waiting for a miss; miss_ready=1
//   WB_REQ  | writeline of the dirty victim presented until accepted
//   RD_REQ  | readline of the missing line presented until accepted
//   RD_WAIT | waiting for the read response or the timeout

module line_refill_engine #(
    parameter int ADDR_W       = 32,
    parameter int LINE_BYTES   = 32,
    parameter int LINE_W       = LINE_BYTES * 8,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              miss_dirty,
    input  logic [ADDR_W-1:0] miss_victim_addr,
    input  logic [LINE_W-1:0] miss_victim_line,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_line,
    output logic              fill_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wline,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_rline,
    output logic              timeout_sticky,
    output logic              spurious_sticky
);

    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int TMR_W       = $clog2(RESP_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(RESP_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WB_REQ  = 2'd1,
        RD_REQ  = 2'd2,
        RD_WAIT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d;
    logic [LINE_W-1:0] vline_q, vline_d;
    logic              dirty_q, dirty_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              fill_valid_q, fill_valid_d;
    logic              fill_err_q, fill_err_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [LINE_W-1:0] fill_line_q, fill_line_d;
    logic              timeout_sticky_q, timeout_sticky_d;
    logic              spurious_sticky_q, spurious_sticky_d;

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        vaddr_d           = vaddr_q;
        vline_d           = vline_q;
        dirty_d           = dirty_q;
        timer_d           = timer_q;
        fill_valid_d      = 1'b0;
        fill_err_d        = fill_err_q;
        fill_addr_d       = fill_addr_q;
        fill_line_d       = fill_line_q;
        timeout_sticky_d  = timeout_sticky_q;
        spurious_sticky_d = spurious_sticky_q | (mem_resp_valid && (state_q != RD_WAIT));

        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    addr_d  = miss_addr & LINE_MASK;
                    vaddr_d = miss_victim_addr & LINE_MASK;
                    vline_d = miss_victim_line;
                    dirty_d = miss_dirty;
                    state_d = miss_dirty ? WB_REQ : RD_REQ;
                end
            end
            WB_REQ: begin
                if (mem_req_ready) state_d = RD_REQ;
            end
            RD_REQ: begin
                if (mem_req_ready) begin
                    state_d = RD_WAIT;
                    timer_d = '0;
                end
            end
            RD_WAIT: begin
                if (timer_q != TMR_MAX) timer_d = timer_q + TMR_W'(1);
                // A response arriving on the expiry cycle still counts as good data.
                if (mem_resp_valid) begin
                    fill_valid_d = 1'b1;
                    fill_err_d   = 1'b0;
                    fill_line_d  = mem_resp_rline;
                    fill_addr_d  = addr_q;
                    state_d      = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    fill_valid_d     = 1'b1;
                    fill_err_d       = 1'b1;
                    fill_line_d      = '0;
                    fill_addr_d      = addr_q;
                    timeout_sticky_d = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            vaddr_q           <= '0;
            vline_q           <= '0;
            dirty_q           <= 1'b0;
            timer_q           <= '0;
            fill_valid_q      <= 1'b0;
            fill_err_q        <= 1'b0;
            fill_addr_q       <= '0;
            fill_line_q       <= '0;
            timeout_sticky_q  <= 1'b0;
            spurious_sticky_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            vaddr_q           <= vaddr_d;
            vline_q           <= vline_d;
            dirty_q           <= dirty_d;
            timer_q           <= timer_d;
            fill_valid_q      <= fill_valid_d;
            fill_err_q        <= fill_err_d;
            fill_addr_q       <= fill_addr_d;
            fill_line_q       <= fill_line_d;
            timeout_sticky_q  <= timeout_sticky_d;
            spurious_sticky_q <= spurious_sticky_d;
        end
    end

    // Request channel is decoded purely from registered state, so no input
    // reaches an output combinationally and fields stay stable under backpressure.
    assign miss_ready      = (state_q == IDLE);
    assign mem_req_valid   = (state_q == WB_REQ) || (state_q == RD_REQ);
    assign mem_req_rw      = (state_q == WB_REQ);
    assign mem_req_addr    = (state_q == WB_REQ) ? vaddr_q :
                             (state_q == RD_REQ) ? addr_q  : '0;
    assign mem_req_wline   = ((state_q == WB_REQ) && dirty_q) ? vline_q : '0;

    assign fill_valid      = fill_valid_q;
    assign fill_err        = fill_err_q;
    assign fill_addr       = fill_addr_q;
    assign fill_line       = fill_line_q;
    assign timeout_sticky  = timeout_sticky_q;
    assign spurious_sticky = spurious_sticky_q;

endmodule
